// File: rtl/dac_spi_tx.sv
// dac_spi_tx: converts filtered Q9.16 samples to 12-bit offset-binary DAC
// codes (with saturation) and shifts them out as 16-bit SPI frames.
// A one-deep holding register absorbs samples arriving mid-frame; the newest
// sample wins.
// Optional feature: define DAC_SPI_DROP_CNT_EN to add the drop_cnt output,
// a saturating count of pending samples overwritten before being sent.
module dac_spi_tx #(
  parameter int DIN_W   = 25,
  parameter int FRAC_W  = 16,
  parameter int CLK_DIV = 1,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_2,
  input  logic [DIN_W-1:0] y,
  output logic             sync_n,
  output logic             sclk,
  output logic             sdata,
  output logic             busy,
  output logic             done,
  output logic             sat
`ifdef DAC_SPI_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int SH = FRAC_W - 11;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  // Clip window: [-1.0, +1.0 - 1 LSB of the 12-bit code]
  localparam logic signed [DIN_W-1:0] MAXV = DIN_W'((1 << FRAC_W) - (1 << SH));
  localparam logic signed [DIN_W-1:0] MINV = DIN_W'(-(1 << FRAC_W));

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t                   state;
  logic signed [DIN_W-1:0]  hold;
  logic                     pending;
  logic [15:0]              shreg;
  logic [3:0]               bit_cnt;
  logic [DW-1:0]            div_cnt;
  logic                     hi_ph;
  logic [GW-1:0]            gap_cnt;

  logic signed [DIN_W-1:0]  nxt_hold;
  logic signed [DIN_W-1:0]  clip_v;
  logic [11:0]              code;
  logic                     unused_frac;

  function automatic logic is_clip(input logic signed [DIN_W-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Conversion of the held sample: clip, drop fraction bits (floor), then
  // flipping the sign bit of the 12-bit result is the +2048 offset.
  always_comb begin
    nxt_hold = rx_2 ? $signed(y) : hold;
    clip_v   = hold;
    if (hold > MAXV)      clip_v = MAXV;
    else if (hold < MINV) clip_v = MINV;
    code = {~clip_v[FRAC_W], clip_v[FRAC_W-1:SH]};
  end

  assign unused_frac = ^clip_v[SH-1:0];

  // Frame sequencer, holding register and registered SPI outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hold    <= '0;
      pending <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      hi_ph   <= 1'b0;
      gap_cnt <= '0;
      sync_n  <= 1'b1;
      sclk    <= 1'b1;
      sdata   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      done <= 1'b0;
      sat  <= 1'b0;
      if (rx_2) hold <= y;
      // A strobe during LOAD re-arms pending even though LOAD consumes it
      if (rx_2 && state != IDLE) pending <= 1'b1;
      else if (state == LOAD)    pending <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_2) begin
            state <= LOAD;
            busy  <= 1'b1;
            sat   <= is_clip(y);
          end
        end
        LOAD: begin
          // Bit 15 goes out now; shreg holds the remaining 15 bits MSB-aligned
          state   <= SHIFT;
          shreg   <= {3'b000, code, 1'b0};
          sdata   <= 1'b0;
          sync_n  <= 1'b0;
          sclk    <= 1'b1;
          hi_ph   <= 1'b1;
          bit_cnt <= 4'd15;
          div_cnt <= '0;
        end
        SHIFT: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (hi_ph) begin
              sclk  <= 1'b0;
              hi_ph <= 1'b0;
            end else if (bit_cnt == 4'd0) begin
              state   <= GAP;
              sync_n  <= 1'b1;
              sclk    <= 1'b1;
              sdata   <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              sclk    <= 1'b1;
              hi_ph   <= 1'b1;
              sdata   <= shreg[15];
              shreg   <= {shreg[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            // A strobe on the last gap cycle still chains straight into LOAD
            if (pending || rx_2) begin
              state <= LOAD;
              sat   <= is_clip(nxt_hold);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAC_SPI_DROP_CNT_EN
  // Count pending samples overwritten unsent; in LOAD the pending sample is
  // already being converted, so a strobe there is not a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (rx_2 && pending && state != LOAD && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: randomized + directed bench for dac_spi_tx. Two instances
// (default timing and CLK_DIV=3/GAP_CYC=4) share stimulus; a cycle-level
// transaction model predicts the frame sequence and an SPI monitor decodes
// each frame from sclk falling edges.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_2 = 1'b0;
  logic [24:0] y = '0;
  logic [1:0]  sync_n, sclk, sdata, busy, done, sat;
`ifdef DAC_SPI_DROP_CNT_EN
  logic [7:0]  drop_cnt0, drop_cnt1;
`endif

  dac_spi_tx dut (
    .clk(clk), .rst(rst), .rx_2(rx_2), .y(y),
    .sync_n(sync_n[0]), .sclk(sclk[0]), .sdata(sdata[0]),
    .busy(busy[0]), .done(done[0]), .sat(sat[0])
`ifdef DAC_SPI_DROP_CNT_EN
    , .drop_cnt(drop_cnt0)
`endif
  );

  dac_spi_tx #(.CLK_DIV(3), .GAP_CYC(4)) dut3 (
    .clk(clk), .rst(rst), .rx_2(rx_2), .y(y),
    .sync_n(sync_n[1]), .sclk(sclk[1]), .sdata(sdata[1]),
    .busy(busy[1]), .done(done[1]), .sat(sat[1])
`ifdef DAC_SPI_DROP_CNT_EN
    , .drop_cnt(drop_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference conversion: {sat, code[11:0]} from plain integer arithmetic
  function automatic int conv(input logic [24:0] v);
    int s;
    s = int'($signed(v));
    if (s > 65536 - 32) return 4096 + 4095;
    if (s < -65536)     return 4096;
    return (s >>> 5) + 2048;   // floor(s / 32) + 2048
  endfunction

  // ---------------- transaction model ----------------
  int          cdv[2]  = '{1, 3};
  int          gapv[2] = '{2, 4};
  longint      e = 0;
  longint      end_e[2];
  bit          mbusy[2], mpend[2];
  logic [24:0] mpv[2];
  int          drops[2] = '{0, 0};
  int          expq0[$], expq1[$];

  function automatic void mstart(input int k, input logic [24:0] v);
    if (k == 0) expq0.push_back(conv(v)); else expq1.push_back(conv(v));
    mbusy[k] = 1'b1;
    mpend[k] = 1'b0;
    end_e[k] = e + 1 + 32 * cdv[k] + gapv[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mbusy[k] = 1'b0;
        mpend[k] = 1'b0;
        if (k == 0) expq0.delete(); else expq1.delete();
      end else if (mbusy[k] && e == end_e[k]) begin
        if (rx_2) begin
          if (mpend[k]) drops[k]++;
          mstart(k, y);
        end else if (mpend[k]) mstart(k, mpv[k]);
        else mbusy[k] = 1'b0;
      end else if (mbusy[k]) begin
        if (rx_2) begin
          if (mpend[k]) drops[k]++;
          mpend[k] = 1'b1;
          mpv[k]   = y;
        end
      end else if (rx_2) begin
        mstart(k, y);
      end
    end
    e++;
  end

  // ---------------- SPI monitor ----------------
  logic [1:0]  psclk, psync;
  int          nbits[2], lowc[2], hic[2], last_hi[2], frames[2], donec[2];
  bit          satseen[2], last_sat[2];
  logic [15:0] word[2], last_word[2];

  function automatic int pop_exp(input int k);
    if (k == 0) return (expq0.size() > 0) ? expq0.pop_front() : -1;
    return (expq1.size() > 0) ? expq1.pop_front() : -1;
  endfunction

  initial begin
    frames = '{0, 0};
    donec  = '{0, 0};
    last_hi = '{0, 0};
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        nbits[k] = 0; lowc[k] = 0; hic[k] = 0; satseen[k] = 1'b0;
        psclk[k] = 1'b1; psync[k] = 1'b1;
      end else begin
        if (sat[k]) satseen[k] = 1'b1;
        if (done[k]) donec[k]++;
        if (sync_n[k] == 1'b0) begin
          lowc[k]++;
          if (psync[k]) begin
            last_hi[k] = hic[k];
            hic[k] = 0;
          end
          if (psclk[k] && !sclk[k]) begin
            word[k] = {word[k][14:0], sdata[k]};
            nbits[k]++;
          end
        end else begin
          if (!psync[k]) begin
            int ex;
            ex = pop_exp(k);
            chk($sformatf("frame_expected%0d", k), int'(ex >= 0), 1);
            chk($sformatf("frame_bits%0d", k), nbits[k], 16);
            chk($sformatf("frame_low%0d", k), lowc[k], 32 * cdv[k]);
            chk($sformatf("frame_done%0d", k), int'(done[k]), 1);
            if (ex >= 0) begin
              chk($sformatf("frame_word%0d", k), int'(word[k]), ex % 4096);
              chk($sformatf("frame_sat%0d", k), int'(satseen[k]), ex / 4096);
            end
            last_word[k] = word[k];
            last_sat[k]  = satseen[k];
            frames[k]++;
            nbits[k] = 0; lowc[k] = 0; hic[k] = 0; satseen[k] = 1'b0;
          end
          hic[k]++;
        end
        psclk[k] = sclk[k];
        psync[k] = sync_n[k];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [24:0] v);
    @(negedge clk);
    rx_2 = 1'b1;
    y    = v;
    @(negedge clk);
    rx_2 = 1'b0;
  endtask

  logic [24:0] dir_y[8]   = '{25'h0000000, 25'h0008000, 25'h1FF8000, 25'h1FFFFFF,
                              25'h000001F, 25'h0010000, 25'h1F00000, 25'h1FF0000};
  int          dir_code[8] = '{'h800, 'hC00, 'h400, 'h7FF, 'h800, 'hFFF, 'h000, 'h000};
  int          dir_sat[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
  int          bnd[8]      = '{-65536, -65537, 65504, 65505, 65503, -1, 0, 65535};

  initial begin
    logic [24:0] v;
    int t, cnt;

    // Reset state
    idle(3);
    chk("rst_sync_n", int'(sync_n[0]), 1);
    chk("rst_sclk",   int'(sclk[0]), 1);
    chk("rst_sdata",  int'(sdata[0]), 0);
    chk("rst_busy",   int'(busy[0]), 0);
    chk("rst_done",   int'(done[0]), 0);
    chk("rst_sat",    int'(sat[0]), 0);
    rst = 1'b1;
    idle(2);

    // Latency: LOAD after E0, sync_n falls with sclk high at E1
    @(negedge clk);
    rx_2 = 1'b1;
    y    = dir_y[0];
    @(posedge clk);
    #1;
    rx_2 = 1'b0;
    chk("load_busy",    int'(busy[0]), 1);
    chk("load_sync_hi", int'(sync_n[0]), 1);
    @(posedge clk);
    #1;
    chk("e1_sync_lo", int'(sync_n[0]), 0);
    chk("e1_sclk_hi", int'(sclk[0]), 1);
    chk("e1_bit15",   int'(sdata[0]), 0);
    idle(110);
    chk("dir_word0", int'(last_word[0]), dir_code[0]);

    // Directed conversion table, both timings
    for (int i = 1; i < 8; i++) begin
      strobe(dir_y[i]);
      idle(110);
      chk($sformatf("dir_word%0d", i),   int'(last_word[0]), dir_code[i]);
      chk($sformatf("dir_sat%0d", i),    int'(last_sat[0]), dir_sat[i]);
      chk($sformatf("dir_word3_%0d", i), int'(last_word[1]), dir_code[i]);
    end

    // Back-to-back: strobes every 16 cycles, the next LOAD follows the gap
    for (int i = 0; i < 6; i++) begin
      strobe(25'($urandom()));
      if (i == 3) chk("b2b_hi_run", last_hi[0], 3);
      idle(14);
    end
    idle(250);

    // Reset in the middle of a frame
    strobe(25'h0008000);
    cnt = 0;
    while (nbits[0] < 8 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_frame_reached", int'(cnt < 100), 1);
    rst = 1'b0;
    #1;
    chk("midrst_sync_n", int'(sync_n[0]), 1);
    chk("midrst_sclk",   int'(sclk[0]), 1);
    chk("midrst_sdata",  int'(sdata[0]), 0);
    chk("midrst_busy",   int'(busy[0]), 0);
    chk("midrst_busy3",  int'(busy[1]), 0);
    idle(3);
    rst = 1'b1;
    idle(3);
    strobe(25'h1FF8000);
    idle(110);
    chk("postrst_word",  int'(last_word[0]), 'h400);
    chk("postrst_word3", int'(last_word[1]), 'h400);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: v = 25'($urandom());
        1: begin
          t = int'($urandom_range(0, 140000)) - 70000;
          v = t[24:0];
        end
        default: begin
          t = bnd[$urandom_range(0, 7)];
          v = t[24:0];
        end
      endcase
      strobe(v);
      idle(int'($urandom_range(0, 60)));
    end
    idle(300);

    chk("q0_drained", expq0.size(), 0);
    chk("q1_drained", expq1.size(), 0);
    chk("done_count0", donec[0], frames[0]);
    chk("done_count3", donec[1], frames[1]);
`ifdef DAC_SPI_DROP_CNT_EN
    chk("drop_cnt0", int'(drop_cnt0), (drops[0] > 255) ? 255 : drops[0]);
    chk("drop_cnt3", int'(drop_cnt1), (drops[1] > 255) ? 255 : drops[1]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Output stage downstream of the 200 Hz low-pass filter: consumes each filtered sample (`y` qualified by the one-cycle `rx_2` strobe), converts the signed 25-bit fixed-point value to a 12-bit offset-binary DAC code with saturation, and shifts it out as a 16-bit SPI frame to an external 12-bit DAC. A one-deep holding register absorbs samples that arrive while a frame is in flight, so the filter never stalls.

## Interface
- `DIN_W`, 25, width of input sample `y` (signed two's complement)
- `FRAC_W`, 16, fractional bits of `y`; ±1.0 = DAC full scale
- `CLK_DIV`, 1, `sclk` half-period in `clk` cycles (≥1)
- `GAP_CYC`, 2, minimum `sync_n`-high cycles between frames (≥1)

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `rx_2`  in  1  one-cycle strobe: `y` valid
- `y`  in  DIN_W  filtered sample, Q(DIN_W-FRAC_W).FRAC_W
- `sync_n`  out  1  DAC frame select, active low; reset 1
- `sclk`  out  1  serial clock, idles high; reset 1
- `sdata`  out  1  serial data, MSB first; reset 0
- `busy`  out  1  high in LOAD/SHIFT/GAP; reset 0
- `done`  out  1  one-cycle pulse at frame end; reset 0
- `sat`  out  1  one-cycle pulse in LOAD when the code was clipped; reset 0

## Operation
- FSM states IDLE, LOAD, SHIFT, GAP; reset state IDLE.
- IDLE: on `rx_2`=1, capture `y` into `hold`, go to LOAD.
- LOAD (1 cycle): convert `hold` and load the 16-bit shift register `{4'b0000, code[11:0]}`; clear `pending`; go to SHIFT.
- Conversion: clip `hold` to [-2^FRAC_W, 2^FRAC_W - 2^(FRAC_W-11)]; arithmetic right shift by FRAC_W-11 (truncation toward -inf); add 2048, which yields `code` in 0..4095. `sat`=1 when clipping occurred.
- SHIFT: 16 bits, MSB first. Each bit is `sclk` high for CLK_DIV cycles, then low for CLK_DIV cycles. `sdata` changes only at the start of the high phase; the DAC samples on the falling edge. `sync_n`=0 throughout. After the low phase of bit 0, go to GAP.
- GAP: `sync_n`=1, `sclk`=1, `sdata`=0 for GAP_CYC cycles. `done`=1 in the first GAP cycle. On exit, go to LOAD if `pending`=1, else IDLE.
- Holding register: `rx_2`=1 in LOAD/SHIFT/GAP overwrites `hold` with `y` and sets `pending`. The newest sample wins and an older pending sample is discarded. `rx_2` in the same cycle that LOAD clears `pending` leaves `pending`=1.

## Timing
- Strobe sampled at edge E0 in IDLE → LOAD after E0. At E1: `sync_n`↓, `sclk`=1, `sdata`=bit15, all simultaneously.
- Frame: 1 (LOAD) + 32·CLK_DIV (SHIFT) + GAP_CYC cycles. Defaults give 35 cycles from LOAD entry to next LOAD/IDLE.
- `sync_n` is low for exactly 32·CLK_DIV cycles per frame.
- Back-to-back: a pending sample starts LOAD immediately after the last GAP cycle. No IDLE cycle is inserted.
- Reset asserted mid-frame: all outputs take their reset values asynchronously, FSM goes to IDLE, `pending`/`hold`/shift register clear. No partial frame resumes after release.

## Configuration
- `DAC_SPI_DROP_CNT_EN` defined: adds output `drop_cnt` [7:0] (reset 0). It increments, saturating at 255, whenever `rx_2`=1 while `pending`=1 already (sample overwritten unsent). Cleared only by reset.
- Undefined: no `drop_cnt` port and no counter logic. Overwrite behaviour is unchanged.

## Test plan
- `y`=0x0000000 strobe from IDLE → `sync_n`↓ 2 edges after strobe; 16 bits captured on `sclk`↓ = 0x0800; `done` pulse once; `sat`=0.
- `y`=0x0008000 (+0.5) → 0x0C00; `y`=0x1FF8000 (-0.5) → 0x0400; `y`=0x1FFFFFF (-2^-16) → 0x07FF; `y`=0x000001F → 0x0800.
- `y`=0x0010000 (+1.0) → 0x0FFF with `sat` pulse; `y`=0x1F00000 → 0x0000 with `sat` pulse; `y`=0x1FF0000 (-1.0) → 0x0000 with `sat`=0.
- Strobes every 16 cycles (`y`=A, B, C, D…) with CLK_DIV=1 → frames back-to-back, each LOAD directly after GAP. The frames sent are A, then the newest pending value (C), and so on. With `DAC_SPI_DROP_CNT_EN`, `drop_cnt` counts each overwritten pending sample.
- Reset low at bit 7 of a frame → `sync_n`=1, `sclk`=1, `sdata`=0, `busy`=0 immediately. After release, the next strobe produces a complete, correct 16-bit frame.
- CLK_DIV=3, GAP_CYC=4 → `sync_n` low 96 cycles, `sclk` period 6 cycles, GAP 4 cycles; frame value unchanged.
